light_output_scheduler: RTL and testbench

//  Decides what the 8-bit hood lamp/indicator bar shows: manual light, a mode-change flash, or a cleaning-reminder blink.

---
 rtl/light_output_scheduler_pkg.sv | 31 +++
 rtl/light_output_scheduler_phase_timer.sv | 34 +++
 rtl/light_output_scheduler.sv | 102 ++++++++++
 tb/tb_light_output_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/light_output_scheduler_pkg.sv
// Shared constants for the hood light output scheduler: widths, LED patterns,
// scheduler state encodings and the state/phase -> LED bar decode.
package light_output_scheduler_pkg;

  localparam int MODE_WIDTH   = 2;
  localparam int OUTPUT_WIDTH = 8;
  localparam logic [MODE_WIDTH-1:0] OFF_MODE = '0;

  localparam logic [OUTPUT_WIDTH-1:0] LED_ALL_ON   = 8'hFF;
  localparam logic [OUTPUT_WIDTH-1:0] LED_ALL_OFF  = 8'h00;
  localparam logic [OUTPUT_WIDTH-1:0] LED_REMIND_A = 8'hAA;
  localparam logic [OUTPUT_WIDTH-1:0] LED_REMIND_B = 8'h55;

  localparam logic [1:0] LS_IDLE   = 2'd0;
  localparam logic [1:0] LS_LIGHT  = 2'd1;
  localparam logic [1:0] LS_FLASH  = 2'd2;
  localparam logic [1:0] LS_REMIND = 2'd3;

  // Phase 0 is the first pattern of each sequence (FF for flash, AA for reminder).
  function automatic logic [OUTPUT_WIDTH-1:0] led_decode(input logic [1:0] st,
                                                         input logic fl_ph,
                                                         input logic bl_ph);
    case (st)
      LS_LIGHT:  led_decode = LED_ALL_ON;
      LS_FLASH:  led_decode = fl_ph ? LED_ALL_OFF : LED_ALL_ON;
      LS_REMIND: led_decode = bl_ph ? LED_REMIND_B : LED_REMIND_A;
      default:   led_decode = LED_ALL_OFF;
    endcase
  endfunction

endpackage

// File: rtl/light_output_scheduler_phase_timer.sv
// Half-period timer: counts HALF enabled cycles, pulses phase_end on the last
// one and toggles phase. clear restarts at count 0, phase 0.
module phase_timer #(
  parameter int HALF = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic phase_end,
  output logic phase
);

  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0] cnt;

  assign phase_end = en && (cnt == CW'(HALF - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (en) begin
      if (phase_end) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/light_output_scheduler.sv
// Chooses what the LED bar shows: manual light, mode-change flash or cleaning
// reminder blink, with auto-off of the manual light.
module light_output_scheduler
  import light_output_scheduler_pkg::*;
#(
  parameter int FLASH_HALF  = 25_000_000,
  parameter int FLASH_COUNT = 3,
  parameter int BLINK_HALF  = 50_000_000,
  parameter int AUTO_OFF    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    light_btn,
  input  logic [MODE_WIDTH-1:0]   current_mode,
  input  logic                    clean_reminder,
  output logic [OUTPUT_WIDTH-1:0] shining,
  output logic                    light_on,
  output logic                    flash_active
);

  localparam int FCW       = (FLASH_COUNT > 1) ? $clog2(FLASH_COUNT) : 1;
  localparam int AW        = (AUTO_OFF > 1) ? $clog2(AUTO_OFF) : 1;
  localparam int AUTO_LAST = (AUTO_OFF > 0) ? AUTO_OFF - 1 : 0;

  logic [1:0]            state, state_nxt;
  logic [MODE_WIDTH-1:0] prev_mode;
  logic [FCW-1:0]        flash_cnt;
  logic [AW-1:0]         auto_cnt;

  logic mode_off, flash_start, auto_fire, light_nxt, flash_done;
  logic fl_end, fl_phase, fl_phase_nxt, fl_en;
  logic bl_end, bl_phase, bl_phase_nxt, bl_en, bl_clear;

  assign fl_en = (state == LS_FLASH);
  assign bl_en = (state == LS_REMIND);

  phase_timer #(.HALF(FLASH_HALF)) u_flash_timer (
    .clk(clk), .rst(rst), .clear(flash_start), .en(fl_en),
    .phase_end(fl_end), .phase(fl_phase)
  );

  phase_timer #(.HALF(BLINK_HALF)) u_blink_timer (
    .clk(clk), .rst(rst), .clear(bl_clear), .en(bl_en),
    .phase_end(bl_end), .phase(bl_phase)
  );

  always_comb begin
    mode_off    = (current_mode == OFF_MODE);
    flash_start = (current_mode != prev_mode) && !mode_off;
    auto_fire   = (AUTO_OFF != 0) && light_on && (auto_cnt == AW'(AUTO_LAST));

    light_nxt = light_on;
    if (mode_off)       light_nxt = 1'b0;
    else if (light_btn) light_nxt = ~light_on;
    else if (auto_fire) light_nxt = 1'b0;

    // A flash ends when the off-phase of its last on/off pair expires.
    flash_done = fl_en && fl_end && fl_phase && (flash_cnt == FCW'(FLASH_COUNT - 1));

    if (mode_off)                   state_nxt = LS_IDLE;
    else if (flash_start)           state_nxt = LS_FLASH;
    else if (fl_en && !flash_done)  state_nxt = LS_FLASH;
    else if (light_nxt)             state_nxt = LS_LIGHT;
    else if (clean_reminder)        state_nxt = LS_REMIND;
    else                            state_nxt = LS_IDLE;

    bl_clear = (state_nxt == LS_REMIND) && !bl_en;

    // Timer phases as they will be after this edge, so shining can be registered.
    fl_phase_nxt = flash_start ? 1'b0 : (fl_en ? (fl_phase ^ fl_end) : fl_phase);
    bl_phase_nxt = bl_clear    ? 1'b0 : (bl_en ? (bl_phase ^ bl_end) : bl_phase);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LS_IDLE;
      shining      <= LED_ALL_OFF;
      light_on     <= 1'b0;
      flash_active <= 1'b0;
      prev_mode    <= OFF_MODE;
      flash_cnt    <= '0;
      auto_cnt     <= '0;
    end else begin
      state        <= state_nxt;
      shining      <= led_decode(state_nxt, fl_phase_nxt, bl_phase_nxt);
      light_on     <= light_nxt;
      flash_active <= (state_nxt == LS_FLASH);
      prev_mode    <= current_mode;

      if (flash_start)
        flash_cnt <= '0;
      else if (fl_en && fl_end && fl_phase)
        flash_cnt <= flash_done ? '0 : flash_cnt + 1'b1;

      if ((AUTO_OFF != 0) && light_on && light_nxt && !light_btn)
        auto_cnt <= auto_cnt + 1'b1;
      else
        auto_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_light_output_scheduler.sv
// Bench for light_output_scheduler: scenario tasks plus a randomized run, all
// compared against a cycle-elapsed reference model of the display rules.
module tb_light_output_scheduler;

  localparam int FH = 4;
  localparam int FC = 3;
  localparam int BH = 8;
  localparam int AO = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       light_btn = 1'b0;
  logic [1:0] current_mode = 2'd0;
  logic       clean_reminder = 1'b0;
  logic [7:0] shining;
  logic       light_on, flash_active;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  light_output_scheduler #(
    .FLASH_HALF(FH), .FLASH_COUNT(FC), .BLINK_HALF(BH), .AUTO_OFF(AO)
  ) dut (
    .clk(clk), .rst(rst), .light_btn(light_btn), .current_mode(current_mode),
    .clean_reminder(clean_reminder), .shining(shining), .light_on(light_on),
    .flash_active(flash_active)
  );

  // Reference model: tracks elapsed cycles in flash / reminder and light age.
  logic [7:0] m_shine = 8'h00;
  logic       m_light = 1'b0;
  logic       m_fa = 1'b0;
  logic [1:0] m_prev = 2'd0;
  bit         m_rem = 1'b0;
  int         m_fl_t = 0, m_rem_t = 0, m_age = 0;

  task automatic model_update();
    bit off, chg, old_l;
    if (rst) begin
      m_shine = 8'h00; m_light = 0; m_fa = 0; m_prev = 2'd0;
      m_rem = 0; m_age = 0; m_fl_t = 0; m_rem_t = 0;
    end else begin
      off = (current_mode == 2'd0);
      chg = (current_mode != m_prev);
      m_prev = current_mode;
      old_l = m_light;
      if (off) m_light = 0;
      else if (light_btn) m_light = !m_light;
      else if (m_light && m_age == AO - 1) m_light = 0;
      m_age = (m_light && old_l && !light_btn) ? m_age + 1 : 0;
      if (off) begin
        m_fa = 0; m_rem = 0; m_shine = 8'h00;
      end else begin
        if (chg) begin
          m_fa = 1; m_fl_t = 0;
        end else if (m_fa) begin
          m_fl_t++;
          if (m_fl_t == 2 * FH * FC) m_fa = 0;
        end
        if (m_fa) begin
          m_rem = 0; m_shine = ((m_fl_t / FH) % 2) ? 8'h00 : 8'hFF;
        end else if (m_light) begin
          m_rem = 0; m_shine = 8'hFF;
        end else if (clean_reminder) begin
          if (m_rem) m_rem_t++;
          else begin m_rem = 1; m_rem_t = 0; end
          m_shine = ((m_rem_t / BH) % 2) ? 8'h55 : 8'hAA;
        end else begin
          m_rem = 0; m_shine = 8'h00;
        end
      end
    end
  endtask

  // Drive inputs for one cycle; returns at the following negedge.
  task automatic step(input logic b, input logic [1:0] m, input logic c, input logic r);
    light_btn = b; current_mode = m; clean_reminder = c; rst = r;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    checks++;
    if ({shining, light_on, flash_active} !== {8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset: got sh=%h lo=%b fa=%b want sh=00 lo=0 fa=0", shining, light_on, flash_active);
    end
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 1, 0);
    checks++;
    if ({shining, light_on} !== {8'h00, 1'b0} || {shining, light_on} !== {m_shine, m_light}) begin
      failures++;
      $display("FAIL off_btn_ignored: got sh=%h lo=%b want sh=00 lo=0", shining, light_on);
    end
    step(0, 0, 0, 0);
  endtask

  task automatic test_flash();
    logic [7:0] exp_sh;
    int bad = 0;
    step(0, 1, 0, 0);
    for (int i = 0; i < 2 * FH * FC; i++) begin
      exp_sh = ((i / FH) % 2) ? 8'h00 : 8'hFF;
      if ({shining, flash_active} !== {exp_sh, 1'b1} || shining !== m_shine) begin
        bad++;
        $display("FAIL flash_pattern c%0d: got sh=%h fa=%b want sh=%h fa=1", i, shining, flash_active, exp_sh);
      end
      step(0, 1, 0, 0);
    end
    checks++;
    if (bad != 0) failures++;
    checks++;
    if ({shining, flash_active, light_on} !== {8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL flash_end: got sh=%h fa=%b lo=%b want sh=00 fa=0 lo=0", shining, flash_active, light_on);
    end
  endtask

  task automatic test_light();
    int bad = 0;
    step(1, 1, 0, 0);
    checks++;
    if ({shining, light_on} !== {8'hFF, 1'b1}) begin
      failures++;
      $display("FAIL light_on: got sh=%h lo=%b want sh=ff lo=1", shining, light_on);
    end
    repeat (4) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    checks++;
    if ({shining, light_on} !== {8'h00, 1'b0}) begin
      failures++;
      $display("FAIL light_off: got sh=%h lo=%b want sh=00 lo=0", shining, light_on);
    end
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    for (int i = 0; i < AO; i++) begin
      if ({shining, light_on} !== {8'hFF, 1'b1}) begin
        bad++;
        $display("FAIL auto_off_hold c%0d: got sh=%h lo=%b want sh=ff lo=1", i, shining, light_on);
      end
      step(0, 1, 0, 0);
    end
    checks++;
    if (bad != 0) failures++;
    checks++;
    if ({shining, light_on} !== {8'h00, 1'b0} || {shining, light_on} !== {m_shine, m_light}) begin
      failures++;
      $display("FAIL auto_off: got sh=%h lo=%b want sh=00 lo=0", shining, light_on);
    end
  endtask

  task automatic test_remind();
    logic [7:0] exp_sh;
    int bad = 0;
    step(0, 1, 1, 0);
    for (int i = 0; i < 4 * BH; i++) begin
      exp_sh = ((i / BH) % 2) ? 8'h55 : 8'hAA;
      if (shining !== exp_sh || shining !== m_shine) begin
        bad++;
        $display("FAIL remind_pattern c%0d: got sh=%h want sh=%h", i, shining, exp_sh);
      end
      step((i == 4 * BH - 1), 1, 1, 0);
    end
    checks++;
    if (bad != 0) failures++;
    checks++;
    if ({shining, light_on} !== {8'hFF, 1'b1}) begin
      failures++;
      $display("FAIL remind_btn_light: got sh=%h lo=%b want sh=ff lo=1", shining, light_on);
    end
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    step(1, 1, 1, 0);
    bad = 0;
    for (int i = 0; i < BH + 2; i++) begin
      exp_sh = (i < BH) ? 8'hAA : 8'h55;
      if (shining !== exp_sh || {shining, light_on} !== {m_shine, m_light}) begin
        bad++;
        $display("FAIL remind_restart c%0d: got sh=%h want sh=%h", i, shining, exp_sh);
      end
      step(0, 1, 1, 0);
    end
    checks++;
    if (bad != 0) failures++;
    step(0, 1, 0, 0);
  endtask

  task automatic test_flash_interactions();
    logic [7:0] exp_sh;
    int bad = 0;
    step(0, 2, 0, 0);
    for (int i = 0; i < 2 * FH * FC; i++) begin
      exp_sh = ((i / FH) % 2) ? 8'h00 : 8'hFF;
      if ({shining, flash_active} !== {exp_sh, 1'b1}) begin
        bad++;
        $display("FAIL flash_btn c%0d: got sh=%h fa=%b want sh=%h fa=1", i, shining, flash_active, exp_sh);
      end
      step((i == 10), 2, 0, 0);
    end
    checks++;
    if (bad != 0) failures++;
    checks++;
    if ({shining, light_on, flash_active} !== {8'hFF, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL flash_then_light: got sh=%h lo=%b fa=%b want sh=ff lo=1 fa=0", shining, light_on, flash_active);
    end
    step(1, 3, 0, 0);
    repeat (9) step(0, 3, 0, 0);
    step(0, 2, 0, 0);
    bad = 0;
    for (int i = 0; i < 2 * FH * FC; i++) begin
      exp_sh = ((i / FH) % 2) ? 8'h00 : 8'hFF;
      if ({shining, flash_active} !== {exp_sh, 1'b1} ||
          {shining, light_on, flash_active} !== {m_shine, m_light, m_fa}) begin
        bad++;
        $display("FAIL flash_restart c%0d: got sh=%h fa=%b want sh=%h fa=1", i, shining, flash_active, exp_sh);
      end
      step(0, 2, 0, 0);
    end
    checks++;
    if (bad != 0) failures++;
    checks++;
    if (flash_active !== 1'b0 || {shining, light_on} !== {m_shine, m_light}) begin
      failures++;
      $display("FAIL flash_restart_end: got sh=%h lo=%b fa=%b want sh=%h lo=%b fa=0",
               shining, light_on, flash_active, m_shine, m_light);
    end
  endtask

  task automatic test_abort();
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    checks++;
    if ({shining, light_on, flash_active} !== {8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL off_mid_flash: got sh=%h lo=%b fa=%b want sh=00 lo=0 fa=0", shining, light_on, flash_active);
    end
    step(0, 3, 0, 0);
    repeat (3) step(0, 3, 0, 0);
    step(0, 3, 0, 1);
    checks++;
    if ({shining, light_on, flash_active} !== {8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL rst_mid_flash: got sh=%h lo=%b fa=%b want sh=00 lo=0 fa=0", shining, light_on, flash_active);
    end
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    repeat (2 * FH * FC) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    checks++;
    if ({shining, light_on} !== {8'h00, 1'b0}) begin
      failures++;
      $display("FAIL off_with_light: got sh=%h lo=%b want sh=00 lo=0", shining, light_on);
    end
  endtask

  task automatic test_random();
    logic [1:0] m = 2'd1;
    logic c = 1'b0;
    logic b, r;
    int bad = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 39) == 0) m = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) c = ~c;
      b = ($urandom_range(0, 11) == 0);
      r = ($urandom_range(0, 399) == 0);
      step(b, m, c, r);
      if ({shining, light_on, flash_active} !== {m_shine, m_light, m_fa}) begin
        bad++;
        if (bad < 10)
          $display("FAIL random c%0d: got sh=%h lo=%b fa=%b want sh=%h lo=%b fa=%b",
                   i, shining, light_on, flash_active, m_shine, m_light, m_fa);
      end
    end
    checks++;
    if (bad != 0) failures++;
  endtask

  initial begin
    test_reset();
    test_flash();
    test_light();
    test_remind();
    test_flash_interactions();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
